// File: rtl/aap_fetch_unit.sv
// AAP instruction fetch stage: holds the PC, issues halfword reads and
// assembles 16/32-bit instructions for the decoder over valid/ready.
module aap_fetch_unit #(
  parameter int unsigned        ADDR_W   = 20,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_data,
  output logic [31:0]       instr_out,
  output logic              instr_is32,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  typedef enum logic [1:0] {
    ISSUE_LO = 2'd0,
    LO       = 2'd1,
    HI       = 2'd2,
    OUT      = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] pc_plus1;
  logic [15:0]       lo_buf;
  logic              load_lo;
  logic              load_16;
  logic              load_32;
  logic              advance;

  assign pc_plus1 = pc + ADDR_W'(1);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ISSUE_LO;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a redirect always restarts the fetch sequence
  always_comb begin
    state_next = state;
    case (state)
      ISSUE_LO: state_next = LO;
      LO:       state_next = imem_data[15] ? HI : OUT;
      HI:       state_next = OUT;
      OUT:      if (instr_ready) state_next = ISSUE_LO;
      default:  state_next = ISSUE_LO;
    endcase
    if (redirect_valid) state_next = ISSUE_LO;
  end

  // Output decode: memory address and datapath load strobes
  always_comb begin
    imem_addr = pc;
    load_lo   = 1'b0;
    load_16   = 1'b0;
    load_32   = 1'b0;
    advance   = 1'b0;
    case (state)
      ISSUE_LO: imem_addr = pc;
      LO: begin
        imem_addr = pc_plus1;
        load_lo   = imem_data[15] & ~redirect_valid;
        load_16   = ~imem_data[15] & ~redirect_valid;
      end
      HI: begin
        imem_addr = pc;
        load_32   = ~redirect_valid;
      end
      OUT: begin
        imem_addr = pc;
        advance   = instr_ready & ~redirect_valid;
      end
      default: imem_addr = pc;
    endcase
  end

  // PC update: redirect beats a same-cycle handshake
  always_comb begin
    pc_next = pc;
    if (redirect_valid) begin
      pc_next = redirect_pc;
    end else if (advance) begin
      pc_next = pc + (instr_is32 ? ADDR_W'(2) : ADDR_W'(1));
    end
  end

  // Datapath registers: PC, lo buffer and decoder-facing outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      lo_buf      <= 16'h0000;
      instr_out   <= 32'h0000_0000;
      instr_is32  <= 1'b0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      pc          <= pc_next;
      instr_valid <= (state_next == OUT);
      if (load_lo) begin
        lo_buf <= imem_data;
      end
      if (load_16) begin
        instr_out  <= {16'h0000, imem_data};
        instr_is32 <= 1'b0;
        instr_pc   <= pc;
      end
      if (load_32) begin
        instr_out  <= {imem_data, lo_buf};
        instr_is32 <= 1'b1;
        instr_pc   <= pc;
      end
    end
  end

endmodule
